// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: MDFunc operation codes and the divider state type.
// Used by the divrem top and its testbench.
package muldiv_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } divrem_state_t;

endpackage

// File: rtl/divrem_if.sv
// Request/result bundle of the iterative divider.
// The master drives the operation; the slave returns the result and status.
interface divrem_if #(parameter int DWIDTH = 32) ();

   logic              start;
   logic [2:0]        MDFunc;
   logic [DWIDTH-1:0] A;
   logic [DWIDTH-1:0] B;
   logic [DWIDTH-1:0] MDOut;
   logic              busy;
   logic              done;

   modport master (output start, MDFunc, A, B, input MDOut, busy, done);
   modport slave  (input start, MDFunc, A, B, output MDOut, busy, done);

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
module div_step #(parameter int DWIDTH = 32) (
   input  logic [DWIDTH:0]   rem_in,
   input  logic [DWIDTH-1:0] quo_in,
   input  logic [DWIDTH-1:0] divisor,
   output logic [DWIDTH:0]   rem_out,
   output logic [DWIDTH-1:0] quo_out
);

   logic [DWIDTH+1:0] shifted;
   logic [DWIDTH+1:0] diff;
   logic              fits;

   // Extra top bit keeps the trial subtraction sign-correct for any remainder value.
   always_comb begin
      shifted = {rem_in, quo_in[DWIDTH-1]};
      diff    = shifted - {2'b00, divisor};
      fits    = ~diff[DWIDTH+1];
      rem_out = fits ? diff[DWIDTH:0] : shifted[DWIDTH:0];
      quo_out = {quo_in[DWIDTH-2:0], fits};
   end

endmodule

// File: rtl/divrem.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: latch magnitudes, DWIDTH restoring steps, then sign fix.
// Optional macro DIVREM_EARLY_OUT_EN answers divide-by-zero and signed overflow in one cycle.
module divrem
   import muldiv_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic    clk,
   input  logic    rst,
   divrem_if.slave bus
);

   localparam int CW = $clog2(DWIDTH);

   divrem_state_t     state, state_next;
   logic [CW-1:0]     count;
   logic [DWIDTH:0]   rem_q;
   logic [DWIDTH-1:0] quo_q, div_q, amag_q, mdout_q;
   logic              sign_a, sign_b, is_rem, div0, ovf;

   logic              accept, in_signed, in_sa, in_sb, in_div0, in_ovf;
   logic [DWIDTH-1:0] in_amag, in_bmag;
   logic [DWIDTH:0]   step_rem;
   logic [DWIDTH-1:0] step_quo;
   logic [DWIDTH-1:0] a_val, q_fix, r_fix, fix_result;

   function automatic logic [DWIDTH-1:0] special_result(input logic rem_op, input logic zero,
                                                        input logic [DWIDTH-1:0] a_orig);
      if (rem_op) return zero ? a_orig : '0;
      else        return zero ? '1 : a_orig;
   endfunction

   always_comb begin
      accept    = bus.start && bus.MDFunc[2] && (state == ST_IDLE || state == ST_DONE);
      in_signed = ~bus.MDFunc[0];
      in_sa     = in_signed & bus.A[DWIDTH-1];
      in_sb     = in_signed & bus.B[DWIDTH-1];
      in_amag   = in_sa ? -bus.A : bus.A;
      in_bmag   = in_sb ? -bus.B : bus.B;
      in_div0   = (bus.B == '0);
      in_ovf    = in_signed && (bus.A == {1'b1, {(DWIDTH-1){1'b0}}}) && (bus.B == '1);
   end

   div_step #(.DWIDTH(DWIDTH)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (div_q),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   // Remainder follows the dividend's sign; sign_a/sign_b are only set for signed ops.
   always_comb begin
      a_val      = sign_a ? -amag_q : amag_q;
      q_fix      = (sign_a ^ sign_b) ? -quo_q : quo_q;
      r_fix      = sign_a ? -rem_q[DWIDTH-1:0] : rem_q[DWIDTH-1:0];
      fix_result = (div0 || ovf) ? special_result(is_rem, div0, a_val)
                                 : (is_rem ? r_fix : q_fix);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
`ifdef DIVREM_EARLY_OUT_EN
               state_next = (in_div0 || in_ovf) ? ST_DONE : ST_RUN;
`else
               state_next = ST_RUN;
`endif
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN:  if (count == '0) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         amag_q  <= '0;
         mdout_q <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         is_rem  <= 1'b0;
         div0    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         count  <= CW'(DWIDTH-1);
         rem_q  <= '0;
         quo_q  <= in_amag;
         amag_q <= in_amag;
         div_q  <= in_bmag;
         sign_a <= in_sa;
         sign_b <= in_sb;
         is_rem <= bus.MDFunc[1];
         div0   <= in_div0;
         ovf    <= in_ovf;
`ifdef DIVREM_EARLY_OUT_EN
         if (in_div0 || in_ovf) mdout_q <= special_result(bus.MDFunc[1], in_div0, bus.A);
`endif
      end else if (state == ST_RUN) begin
         rem_q <= step_rem;
         quo_q <= step_quo;
         if (count != '0) count <= count - 1'b1;
      end else if (state == ST_FIX) begin
         mdout_q <= fix_result;
      end
   end

   assign bus.MDOut = mdout_q;
   assign bus.busy  = (state == ST_RUN) || (state == ST_FIX);
   assign bus.done  = (state == ST_DONE);

endmodule

// File: doc/divrem.md
DIVREM -- requirements
Module: divrem

Interface
REQ-001 Parameter DWIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when module accepts (REQ-010).
REQ-005 MDFunc  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; MDFunc[2]=0 is not a divide.
REQ-006 A  input  DWIDTH  dividend (rs1).
REQ-007 B  input  DWIDTH  divisor (rs2).
REQ-008 MDOut  output  DWIDTH  result, registered.
REQ-009 busy  output  1  high while an operation is in flight; done  output  1  one-cycle result-valid pulse.

Function
REQ-010 Request accepted when start=1 and MDFunc[2]=1 and state is IDLE or DONE; otherwise start is ignored with no state change.
REQ-011 States: IDLE, RUN, FIX, DONE; encoding from the shared package.
REQ-012 IDLE/DONE on accept: latch |A|, |B| (magnitudes for DIV/REM, raw for DIVU/REMU), sign flags, MDFunc; load counter DWIDTH-1; go to RUN.
REQ-013 RUN: one restoring shift-subtract iteration per cycle; counter decrements; at counter 0 go to FIX; RUN lasts exactly DWIDTH cycles.
REQ-014 FIX: quotient negated if signs of A and B differ (signed ops), remainder takes sign of A; select quotient (DIV/DIVU) or remainder (REM/REMU); register into MDOut; go to DONE.
REQ-015 DONE: done=1 for exactly this one cycle; next state IDLE unless a new request is accepted (then RUN).
REQ-016 Latency: start sampled in cycle 0 -> done high in cycle DWIDTH+2 (34 for DWIDTH=32); throughput one op per DWIDTH+2 cycles.
REQ-017 busy=1 in RUN and FIX only; busy=0 in IDLE and DONE; done and busy never both high.
REQ-018 MDOut holds the last result from DONE until the next FIX/DONE write; operand inputs may change freely after acceptance.
REQ-019 Divide by zero (B=0): DIV -> all ones; DIVU -> all ones; REM and REMU -> A.
REQ-020 Signed overflow (A = -2^(DWIDTH-1), B = -1, DIV/REM): DIV -> A; REM -> 0.
REQ-021 Special-case results per REQ-019/020 are forced in FIX regardless of datapath contents.
REQ-022 All arithmetic DWIDTH+1 bits internally for the partial remainder; no result truncation beyond DWIDTH.

Reset
REQ-023 rst=1 at a clock edge: state IDLE, MDOut=0, busy=0, done=0, counter and operand registers 0.
REQ-024 rst during RUN/FIX/DONE abandons the operation; no done pulse is produced for it.
REQ-025 rst has priority over start in the same cycle.

Configuration
REQ-026 Macro DIVREM_EARLY_OUT_EN defined: an accepted request with B=0 or signed overflow goes IDLE/DONE -> DONE directly, result per REQ-019/020, done in cycle 1.
REQ-027 Macro undefined: every request takes full DWIDTH+2 latency; results identical.

Structure
REQ-028 Shared package muldiv_pkg holds MDFunc code constants (MUL..REMU, all eight) and the divrem state typedef.
REQ-029 One combinational sub-module div_step: input partial remainder, quotient, divisor; output next partial remainder and quotient for one iteration.
REQ-030 Sign handling, special-case detection and result select stay in divrem.

Verification
REQ-031 DIVU A=100 B=7 -> MDOut=14, done in cycle 34; REMU same operands -> 2.
REQ-032 DIV A=-7 (0xFFFFFFF9) B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; REM A=7 B=-2 -> 1.
REQ-033 DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000; REM -> 0; done cycle 1 with macro, 34 without.
REQ-034 DIVU 5/0 -> 0xFFFFFFFF; REM A=-5 B=0 -> 0xFFFFFFFB; done cycle 1 with macro, 34 without.
REQ-035 start with MDFunc=000 in IDLE -> no busy; start during RUN -> ignored, original result unchanged; back-to-back start in DONE cycle -> second done exactly 34 cycles later.
REQ-036 rst asserted in cycle 10 of a run -> next cycle busy=0, done=0, MDOut=0; no done pulse; subsequent DIVU 9/3 -> 3.
